// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC quadrant post-correction slice.
// Quadrant codes, default gain and the saturating-negate helper.
package cordic_pkg;

  localparam logic [1:0] Q_ID  = 2'b00;
  localparam logic [1:0] Q_P90 = 2'b01;
  localparam logic [1:0] Q_180 = 2'b10;
  localparam logic [1:0] Q_M90 = 2'b11;

  localparam int unsigned GAIN_DEF = 19898;

  typedef struct packed {
    logic               ovf;
    logic signed [63:0] val;
  } neg_res_t;

  // Negate an n-bit value held sign-extended in 64 bits;
  // the most negative code clamps to the most positive one.
  function automatic neg_res_t sat_neg(
    input logic signed [63:0] x,
    input int unsigned        n
  );
    logic signed [63:0] mn;
    neg_res_t           r;
    mn    = '1;
    mn    = mn <<< (n - 1);
    r.ovf = (x == mn);
    r.val = r.ovf ? ~mn : -x;
    return r;
  endfunction

endpackage

// File: rtl/cordic_gain_comp.sv
// One register stage of CORDIC gain compensation:
// multiply by a Q1.15 constant, round half up, clamp to W bits.
import cordic_pkg::*;

module cordic_gain_comp #(
  parameter int          W    = 24,
  parameter int unsigned GAIN = GAIN_DEF
) (
  input  logic         clk,
  input  logic         aresetn,
  input  logic         en,
  input  logic         in_valid,
  input  logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic         out_valid,
  output logic         sat
);

  localparam int PW = W + 18;

  localparam logic signed [PW-1:0] G   = PW'(GAIN);
  localparam logic signed [PW-1:0] RND = PW'(16384);
  localparam logic signed [PW-1:0] MAXV =
    {19'b0, {(W-1){1'b1}}};
  localparam logic signed [PW-1:0] MINV =
    {{19{1'b1}}, {(W-1){1'b0}}};

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] rnd;
  logic signed [PW-1:0] sh;
  logic                 hi;
  logic                 lo;
  logic [W-1:0]         ysat;

  assign prod = $signed(x) * G;
  assign rnd  = prod + RND;
  assign sh   = rnd >>> 15;
  assign hi   = sh > MAXV;
  assign lo   = sh < MINV;

  // Clamp the rounded product back into the sample range
  always_comb begin
    ysat = sh[W-1:0];
    if (hi) ysat = MAXV[W-1:0];
    if (lo) ysat = MINV[W-1:0];
  end

  assign sat = en && in_valid && (hi || lo);

  // Register stage; holds while the pipe is stalled
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      out_valid <= 1'b0;
      y         <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      if (in_valid) y <= ysat;
    end
  end

endmodule

// File: rtl/cordic_quad_post_pipe.sv
// Quadrant post-correction for the CORDIC sin/cos path:
// rotate by 0/90/180/270 deg, optional gain stage, sat counter.
import cordic_pkg::*;

module cordic_quad_post_pipe #(
  parameter int          W       = 24,
  parameter int          TAG_W   = 2,
  parameter bit          GAIN_EN = 1'b1,
  parameter int unsigned GAIN    = GAIN_DEF,
  parameter int          CNT_W   = 16
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       quadrant,
  input  logic [W-1:0]     cos_pre,
  input  logic [W-1:0]     sin_pre,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     cos,
  output logic [W-1:0]     sin,
  output logic [TAG_W-1:0] tag_out,
  output logic [CNT_W-1:0] sat_cnt,
  input  logic             sat_clr
);

  logic             en;
  logic             acc;
  neg_res_t         nc;
  neg_res_t         ns;
  logic [W-1:0]     ncos;
  logic [W-1:0]     nsin;
  logic             unused_hi;
  logic [W-1:0]     r_cos;
  logic [W-1:0]     r_sin;
  logic [1:0]       ev1;
  logic [1:0]       ev2;
  logic             s1_v;
  logic [W-1:0]     s1_c;
  logic [W-1:0]     s1_s;
  logic [TAG_W-1:0] s1_t;
  logic [2:0]       add;
  logic [CNT_W:0]   sum;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign acc      = in_valid && en;

  assign nc   = sat_neg(64'($signed(cos_pre)), W);
  assign ns   = sat_neg(64'($signed(sin_pre)), W);
  assign ncos = nc.val[W-1:0];
  assign nsin = ns.val[W-1:0];
  assign unused_hi =
    ^{nc.val[63:W], ns.val[63:W]};

  // Quadrant rotation and its negation events
  always_comb begin
    r_cos = cos_pre;
    r_sin = sin_pre;
    ev1   = 2'd0;
    unique case (1'b1)
      quadrant == Q_ID: begin
      end
      quadrant == Q_P90: begin
        r_cos = nsin;
        r_sin = cos_pre;
        ev1   = {1'b0, ns.ovf};
      end
      quadrant == Q_180: begin
        r_cos = ncos;
        r_sin = nsin;
        ev1   = {1'b0, nc.ovf} + {1'b0, ns.ovf};
      end
      quadrant == Q_M90: begin
        r_cos = sin_pre;
        r_sin = ncos;
        ev1   = {1'b0, nc.ovf};
      end
    endcase
  end

  // Stage 1 register: rotated pair, tag and valid
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      s1_v <= 1'b0;
      s1_c <= '0;
      s1_s <= '0;
      s1_t <= '0;
    end else if (en) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_c <= r_cos;
        s1_s <= r_sin;
        s1_t <= tag_in;
      end
    end
  end

  if (GAIN_EN) begin : g_gain
    logic c_v;
    logic s_v;
    logic c_sat;
    logic s_sat;

    cordic_gain_comp #(
      .W    (W),
      .GAIN (GAIN)
    ) u_cos (
      .clk       (clk),
      .aresetn   (aresetn),
      .en        (en),
      .in_valid  (s1_v),
      .x         (s1_c),
      .y         (cos),
      .out_valid (c_v),
      .sat       (c_sat)
    );

    cordic_gain_comp #(
      .W    (W),
      .GAIN (GAIN)
    ) u_sin (
      .clk       (clk),
      .aresetn   (aresetn),
      .en        (en),
      .in_valid  (s1_v),
      .x         (s1_s),
      .y         (sin),
      .out_valid (s_v),
      .sat       (s_sat)
    );

    assign out_valid = c_v & s_v;
    assign ev2       = {1'b0, c_sat} + {1'b0, s_sat};

    // Tag follows its data through the gain stage
    always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
        tag_out <= '0;
      end else if (en && s1_v) begin
        tag_out <= s1_t;
      end
    end
  end else begin : g_bypass
    assign out_valid = s1_v;
    assign cos       = s1_c;
    assign sin       = s1_s;
    assign tag_out   = s1_t;
    assign ev2       = 2'd0;
  end

  assign add = (acc ? {1'b0, ev1} : 3'd0) + {1'b0, ev2};
  assign sum = {1'b0, sat_cnt} + (CNT_W+1)'(add);

  // Saturation counter; clear wins, count sticks at full scale
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      sat_cnt <= '0;
    end else if (sat_clr) begin
      sat_cnt <= '0;
    end else if (sum[CNT_W]) begin
      sat_cnt <= '1;
    end else begin
      sat_cnt <= sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_cordic_quad_post_pipe.sv
// Bench for cordic_quad_post_pipe: GAIN_EN=0 and GAIN_EN=1
// instances side by side against a queue-based reference.
module tb_cordic_quad_post_pipe;

  localparam int  W    = 24;
  localparam int  CW   = 16;
  localparam int  GAIN = 19898;
  localparam longint MAXS = (longint'(1) <<< (W-1)) - 1;
  localparam longint MINS = -MAXS - 1;
  localparam longint CMAX = (longint'(1) <<< CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          aresetn;
  logic          in_valid;
  logic          out_ready;
  logic          sat_clr;
  logic [1:0]    quadrant;
  logic [W-1:0]  cos_pre;
  logic [W-1:0]  sin_pre;
  logic [1:0]    tag_in;

  logic          ir [2];
  logic          ov [2];
  logic [W-1:0]  oc [2];
  logic [W-1:0]  os [2];
  logic [1:0]    ot [2];
  logic [CW-1:0] sc [2];

  cordic_quad_post_pipe #(
    .W(W), .TAG_W(2), .GAIN_EN(1'b0), .GAIN(GAIN), .CNT_W(CW)
  ) u0 (
    .clk(clk), .aresetn(aresetn),
    .in_valid(in_valid), .in_ready(ir[0]),
    .quadrant(quadrant), .cos_pre(cos_pre), .sin_pre(sin_pre),
    .tag_in(tag_in),
    .out_valid(ov[0]), .out_ready(out_ready),
    .cos(oc[0]), .sin(os[0]), .tag_out(ot[0]),
    .sat_cnt(sc[0]), .sat_clr(sat_clr)
  );

  cordic_quad_post_pipe #(
    .W(W), .TAG_W(2), .GAIN_EN(1'b1), .GAIN(GAIN), .CNT_W(CW)
  ) u1 (
    .clk(clk), .aresetn(aresetn),
    .in_valid(in_valid), .in_ready(ir[1]),
    .quadrant(quadrant), .cos_pre(cos_pre), .sin_pre(sin_pre),
    .tag_in(tag_in),
    .out_valid(ov[1]), .out_ready(out_ready),
    .cos(oc[1]), .sin(os[1]), .tag_out(ot[1]),
    .sat_cnt(sc[1]), .sat_clr(sat_clr)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d want %0d",
               nm, $time, act, exp);
    end
  endtask

  function automatic longint sx(input logic [W-1:0] v);
    longint r;
    r = longint'($signed(v));
    return r;
  endfunction

  function automatic longint negm(input longint x);
    return (x == MINS) ? MAXS : -x;
  endfunction

  function automatic longint gm(input longint x);
    longint p;
    p = (x * GAIN + 16384) >>> 15;
    if (p > MAXS) p = MAXS;
    if (p < MINS) p = MINS;
    return p;
  endfunction

  function automatic int gev(input longint x);
    longint p;
    p = (x * GAIN + 16384) >>> 15;
    return (p > MAXS || p < MINS) ? 1 : 0;
  endfunction

  task automatic model_beat(input int d, input logic [1:0] q,
                            input longint c, input longint s,
                            output longint ec, output longint es,
                            output int ev);
    ev = 0;
    ec = c;
    es = s;
    case (q)
      2'd1: begin
        ec = negm(s); es = c; ev = int'(s == MINS);
      end
      2'd2: begin
        ec = negm(c); es = negm(s);
        ev = int'(c == MINS) + int'(s == MINS);
      end
      2'd3: begin
        ec = s; es = negm(c); ev = int'(c == MINS);
      end
      default: ;
    endcase
    if (d == 1) begin
      ev = ev + gev(ec) + gev(es);
      ec = gm(ec);
      es = gm(es);
    end
  endtask

  typedef struct {
    longint c;
    longint s;
    int     t;
    longint k;
  } ent_t;

  ent_t   q0[$];
  ent_t   q1[$];
  longint ecnt [2];
  longint satm [2];

  // Reference check of both instances on every falling edge
  always @(negedge clk) begin
    if (!aresetn) begin
      q0.delete();
      q1.delete();
      ecnt[0] = 0; ecnt[1] = 0;
      satm[0] = 0; satm[1] = 0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        ent_t   h;
        ent_t   n;
        bit     has;
        bit     ev;
        bit     en_m;
        longint ec;
        longint es;
        int     nev;
        has = 1'b0;
        if (d == 0 && q0.size() > 0) begin
          has = 1'b1; h = q0[0];
        end
        if (d == 1 && q1.size() > 0) begin
          has = 1'b1; h = q1[0];
        end
        ev   = has && (h.k + d + 1 == ecnt[d]);
        en_m = !ev || out_ready;
        chk($sformatf("out_valid%0d", d), ov[d], ev);
        chk($sformatf("in_ready%0d", d), ir[d], en_m);
        chk($sformatf("sat_cnt%0d", d), sc[d], satm[d]);
        if (ev) begin
          chk($sformatf("cos%0d", d), sx(oc[d]), h.c);
          chk($sformatf("sin%0d", d), sx(os[d]), h.s);
          chk($sformatf("tag%0d", d), ot[d], h.t);
          if (out_ready) begin
            if (d == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
          end
        end
        nev = 0;
        if (in_valid && en_m) begin
          model_beat(d, quadrant, sx(cos_pre), sx(sin_pre),
                     ec, es, nev);
          n.c = ec; n.s = es; n.t = int'(tag_in); n.k = ecnt[d];
          if (d == 0) q0.push_back(n);
          else        q1.push_back(n);
        end
        if (sat_clr) satm[d] = 0;
        else if (satm[d] + nev > CMAX) satm[d] = CMAX;
        else satm[d] = satm[d] + nev;
        if (en_m) ecnt[d] = ecnt[d] + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] q, input longint c,
                       input longint s, input logic [1:0] t);
    quadrant = q;
    cos_pre  = W'(c);
    sin_pre  = W'(s);
    tag_in   = t;
  endtask

  task automatic beat(input logic [1:0] q, input longint c,
                      input longint s, input logic [1:0] t);
    tick();
    in_valid = 1'b1;
    drive(q, c, s, t);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    aresetn   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sat_clr   = 1'b0;
    drive(2'd0, 0, 0, 2'd0);
    repeat (2) tick();
    for (int d = 0; d < 2; d++) begin
      chk("rst_out_valid", ov[d], 0);
      chk("rst_cos", sx(oc[d]), 0);
      chk("rst_sin", sx(os[d]), 0);
      chk("rst_tag", ot[d], 0);
      chk("rst_sat", sc[d], 0);
    end
    aresetn = 1'b1;
    #1;
    chk("ready_after_rst0", ir[0], 1);
    chk("ready_after_rst1", ir[1], 1);

    beat(2'd2, 70710, -70710, 2'd0);
    chk("t1_valid", ov[0], 1);
    chk("t1_cos", sx(oc[0]), -70710);
    chk("t1_sin", sx(os[0]), 70710);
    chk("t1_sat", sc[0], 0);

    beat(2'd1, 17150, -98520, 2'd3);
    chk("t2_cos", sx(oc[0]), 98520);
    chk("t2_sin", sx(os[0]), 17150);
    chk("t2_tag", ot[0], 3);

    beat(2'd3, MINS, 5, 2'd1);
    chk("t3_cos", sx(oc[0]), 5);
    chk("t3_sin", sx(os[0]), 8388607);
    chk("t3_sat0", sc[0], 1);
    chk("t3_sat1", sc[1], 1);

    beat(2'd0, 100000, -100000, 2'd2);
    tick();
    chk("t4_valid", ov[1], 1);
    chk("t4_cos", sx(oc[1]), 60724);
    chk("t4_sin", sx(os[1]), -60724);
    chk("t4_tag", ot[1], 2);

    for (int i = 0; i < 400; i++) begin
      tick();
      in_valid = $urandom_range(0, 3) != 0;
      drive(2'($urandom),
            ($urandom_range(0, 7) == 0) ? MINS
              : sx(W'($urandom)),
            ($urandom_range(0, 7) == 0) ? MINS
              : sx(W'($urandom)),
            2'($urandom));
      out_ready = $urandom_range(0, 4) != 0;
      sat_clr   = $urandom_range(0, 49) == 0;
      if (i >= 100 && i < 105) begin
        in_valid  = 1'b1;
        out_ready = 1'b0;
      end
      if (i == 104) begin
        chk("stall_ready0", ir[0], 0);
        chk("stall_ready1", ir[1], 0);
      end
      if (i == 300) begin
        #2;
        aresetn = 1'b0;
        #1;
        chk("mid_rst_valid0", ov[0], 0);
        chk("mid_rst_valid1", ov[1], 0);
        chk("mid_rst_sat0", sc[0], 0);
        chk("mid_rst_sat1", sc[1], 0);
        tick();
        aresetn = 1'b1;
      end
    end

    tick();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    sat_clr   = 1'b1;
    tick();
    sat_clr = 1'b0;
    for (int i = 0; i < 32772; i++) begin
      in_valid = 1'b1;
      drive(2'd2, MINS, MINS, 2'(i));
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("sat_hold0", sc[0], 65535);
    chk("sat_hold1", sc[1], 65535);
    in_valid = 1'b1;
    sat_clr  = 1'b1;
    drive(2'd2, MINS, MINS, 2'd1);
    tick();
    in_valid = 1'b0;
    sat_clr  = 1'b0;
    chk("sat_clr_win0", sc[0], 0);
    chk("sat_clr_win1", sc[1], 0);
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cordic_quad_post_pipe.md
# cordic_quad_post_pipe

Parametrised, pipelined quadrant post-correction stage for the CORDIC sin/cos datapath. It takes the first-quadrant-folded cos/sin pair produced by the CORDIC core, together with the quadrant code issued by the pre-rotation stage. It rotates the pair back into the correct quadrant by 0/90/180/270 degrees and optionally applies CORDIC gain compensation. It carries a channel tag, supports valid/ready backpressure and counts saturation events. It sits between the CORDIC iteration core and the NCO/mixer consumers.

## Interface
- W, 24: signed sample width of cos/sin in and out.
- TAG_W, 2: channel tag width, passed through unchanged.
- GAIN_EN, 1: 1 inserts the gain-compensation stage; 0 bypasses it.
- GAIN, 19898: unsigned gain constant, Q1.15 (about 0.6073 × 32768).
- CNT_W, 16: saturation counter width.

Ports (clock and reset first):
- clk  in  1  system clock; all logic on the rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept a beat.
- quadrant  in  2  rotation code from the pre-stage.
- cos_pre  in  W  signed folded cosine.
- sin_pre  in  W  signed folded sine.
- tag_in  in  TAG_W  channel tag.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- cos  out  W  signed corrected cosine.
- sin  out  W  signed corrected sine.
- tag_out  out  TAG_W  tag aligned with cos/sin.
- sat_cnt  out  CNT_W  number of saturated output components since the last clear.
- sat_clr  in  1  synchronous clear of sat_cnt.

## Operation
- Quadrant mapping, with neg(x) = saturating negation:
  - 00: identity, cos=cos_pre, sin=sin_pre.
  - 01: +90°, cos=neg(sin_pre), sin=cos_pre.
  - 10: 180°, cos=neg(cos_pre), sin=neg(sin_pre).
  - 11: −90°, cos=sin_pre, sin=neg(cos_pre).
- Saturating negation: −(−2^(W−1)) yields 2^(W−1)−1 and counts as one saturation event.
- Gain stage (GAIN_EN=1): product = x·GAIN is W+16 bits signed. Add 2^14 for round-half-up, arithmetic-shift right by 15, then clamp to [−2^(W−1), 2^(W−1)−1]. A clamp counts as a saturation event. With GAIN<32768 no clamp occurs, but the clamp logic is still required.
- Saturation events per accepted beat: 0, 1 or 2 (cos and sin counted separately). sat_cnt adds them and holds at 2^CNT_W−1.
- sat_clr has priority over increments in the same cycle; that cycle's events are lost.
- tag travels with its data and is never altered.

## Timing
- Pipeline depth LAT = 1 + GAIN_EN registered stages.
- Stage 1: rotate and negate. Stage 2: gain.
- Global enable: en = !out_valid || out_ready. This gives full throughput of one beat per cycle.
- in_ready = en, combinational; in_ready does not depend on in_valid.
- A beat is accepted when in_valid && in_ready. It appears on out_valid exactly LAT enabled cycles later.
- Bubbles propagate as valid=0 stages; each stage valid bit advances only when en=1.
- While out_valid && !out_ready, cos/sin/tag_out and all stage registers hold stable. No beat is dropped or duplicated.
- Reset values: out_valid=0, cos=0, sin=0, tag_out=0, sat_cnt=0, all internal valid bits 0.
- in_ready after reset deassertion is 1.
- Reset asserted mid-stream discards all in-flight beats immediately.
- sat_cnt updates in the cycle the saturating beat enters stage 1 (negation) or stage 2 (gain), not at output.

## Structure
- Shared package cordic_pkg holds:
  - the quadrant code localparams (Q_ID, Q_P90, Q_180, Q_M90),
  - the default GAIN constant,
  - a function sat_neg(x) returning the saturated value plus an overflow flag.
- One sub-module, cordic_gain_comp: the W-bit multiply / round / clamp register stage, with valid and enable. It is instantiated twice (cos and sin) under a GAIN_EN generate; when GAIN_EN=0 the signal wires through.

## Test plan
- GAIN_EN=0, quadrant=10, cos_pre=70710, sin_pre=−70710, out_ready=1 → cos=−70710, sin=70710 one cycle after accept; sat_cnt=0.
- GAIN_EN=0, quadrant=01, cos_pre=17150, sin_pre=−98520, tag_in=3 → cos=98520, sin=17150, tag_out=3.
- quadrant=11, cos_pre=−8388608, sin_pre=5 → cos=5, sin=8388607; sat_cnt increments by 1.
- GAIN_EN=1, quadrant=00, cos_pre=100000, sin_pre=−100000 → cos=60724, sin=−60724 two cycles after accept.
- Random valid with out_ready held low for 5 cycles mid-burst → outputs stay stable, in_ready=0 while stalled, sequence and tags match the input order with none lost.
- Drive sat_cnt to 65535 with saturating beats, then add more → holds at 65535. Assert sat_clr together with a saturating beat → 0. Assert aresetn low mid-burst → out_valid=0 and sat_cnt=0 immediately.
